// File: rtl/debounce_pkg.sv
// Shared constants for the debounced input controller: arbiter state encoding,
// default tick divide and the edge-direction polarity of ev_rise.
package debounce_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_PRESENT = 1'b1
    } arb_state_t;

    // 100 MHz clock divided down to a 50 Hz sample tick
    localparam logic [20:0] DEFAULT_DIVIDE = 21'd2000000;

    // Value of a channel's new level that is reported as a rising edge
    localparam logic EV_RISE = 1'b1;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, tick-gated agreement counter and
// level register. Emits a one-cycle post strobe with the new level as dir.
module debounce_channel #(
    parameter int STABLE_CNT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic post,
    output logic dir
);

    localparam logic [3:0] LAST = 4'(STABLE_CNT - 1);

    logic       sync0;
    logic       sync1;
    logic [3:0] agree;

    // Acceptance happens on the tick that completes the agreement run
    assign post = tick && (sync1 != level) && (agree == LAST);
    assign dir  = sync1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            level <= 1'b0;
            agree <= '0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            if (tick) begin
                if (sync1 != level) begin
                    if (agree == LAST) begin
                        level <= sync1;
                        agree <= '0;
                    end else begin
                        agree <= agree + 4'd1;
                    end
                end else begin
                    agree <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/debounce_scan_arbiter.sv
// Shared-prescaler debouncer bank whose edge events are serialised by a
// round-robin arbiter onto one valid/ready port with sticky overflow flags.
module debounce_scan_arbiter
    import debounce_pkg::*;
#(
    parameter int                   N_CH       = 4,
    parameter int                   DIV_WIDTH  = 21,
    parameter logic [DIV_WIDTH-1:0] N_DIVIDE   = DIV_WIDTH'(DEFAULT_DIVIDE),
    parameter int                   STABLE_CNT = 2,
    localparam int                  CH_W       = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] in,
    input  logic            enable,
    input  logic            ovf_clr,
    output logic [N_CH-1:0] level,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [CH_W-1:0] ev_ch,
    output logic            ev_rise,
    output logic [N_CH-1:0] overflow
);

    localparam logic [DIV_WIDTH-1:0] TICK_AT = N_DIVIDE - 1'b1;

    logic [DIV_WIDTH-1:0] cnt;
    logic                 tick;
    logic [N_CH-1:0]      post;
    logic [N_CH-1:0]      post_dir;
    logic [N_CH-1:0]      pend;
    logic [N_CH-1:0]      pend_dir;
    logic [N_CH-1:0]      grant_clr;
    logic [CH_W-1:0]      ptr;
    logic [CH_W-1:0]      grant_ch;
    logic                 grant;
    arb_state_t           state;
    arb_state_t           state_next;

    assign tick = enable && (cnt == TICK_AT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CNT(STABLE_CNT)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (in[i]),
            .tick (tick),
            .level(level[i]),
            .post (post[i]),
            .dir  (post_dir[i])
        );
    end

    // Round-robin search starts one past the last granted channel
    always_comb begin
        int idx;
        idx        = 0;
        state_next = state;
        grant      = 1'b0;
        grant_ch   = '0;
        case (state)
            ARB_IDLE: begin
                for (int k = 1; k <= N_CH; k++) begin
                    idx = (int'(ptr) + k) % N_CH;
                    if (!grant && pend[idx]) begin
                        grant    = 1'b1;
                        grant_ch = CH_W'(idx);
                    end
                end
                if (grant) state_next = ARB_PRESENT;
            end
            ARB_PRESENT: begin
                if (ev_ready) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign grant_clr = grant ? (N_CH'(1) << grant_ch) : '0;
    assign ev_valid  = (state == ARB_PRESENT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            ptr     <= '0;
            ev_ch   <= '0;
            ev_rise <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                ptr     <= grant_ch;
                ev_ch   <= grant_ch;
                ev_rise <= (pend_dir[grant_ch] == EV_RISE);
            end
        end
    end

    // A post landing on a slot being granted this cycle refills it cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pend_dir <= '0;
            overflow <= '0;
        end else begin
            if (ovf_clr) overflow <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (post[i]) begin
                    pend[i]     <= 1'b1;
                    pend_dir[i] <= post_dir[i];
                    if (pend[i] && !grant_clr[i]) overflow[i] <= 1'b1;
                end else if (grant_clr[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_debounce_scan_arbiter.sv
// Bench for debounce_scan_arbiter: directed vector table, corner-case sequences
// and randomized traffic, all compared against an in-bench behavioural model.
module tb_debounce_scan_arbiter;

    localparam int NC = 4;
    localparam int ND = 10;
    localparam int SC = 2;

    logic          clk;
    logic          rst_n;
    logic [NC-1:0] in;
    logic          enable;
    logic          ovf_clr;
    logic [NC-1:0] level;
    logic          ev_valid;
    logic          ev_ready;
    logic [1:0]    ev_ch;
    logic          ev_rise;
    logic [NC-1:0] overflow;

    int nchk  = 0;
    int nfail = 0;

    debounce_scan_arbiter #(
        .N_CH      (NC),
        .DIV_WIDTH (8),
        .N_DIVIDE  (8'd10),
        .STABLE_CNT(SC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .enable  (enable),
        .ovf_clr (ovf_clr),
        .level   (level),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_ch   (ev_ch),
        .ev_rise (ev_rise),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: inputs seen two clocks late, sampled on every tick.
    bit [NC-1:0] hist [2];
    bit [NC-1:0] m_lvl, m_pend, m_dir, m_ovf;
    int          m_run [NC];
    int          m_cnt, m_ch, m_ptr;
    bit          m_valid, m_rise;

    task automatic model_reset();
        hist[0] = '0; hist[1] = '0;
        m_lvl = '0; m_pend = '0; m_dir = '0; m_ovf = '0;
        for (int c = 0; c < NC; c++) m_run[c] = 0;
        m_cnt = 0; m_ch = 0; m_ptr = 0; m_valid = 0; m_rise = 0;
    endtask

    task automatic model_step();
        bit          tk;
        bit [NC-1:0] posted, newdir, sample;
        int          g;
        tk     = enable && (m_cnt == ND - 1);
        sample = hist[1];
        posted = '0;
        newdir = '0;
        if (tk) begin
            for (int c = 0; c < NC; c++) begin
                if (sample[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] >= SC) begin
                        m_lvl[c]  = sample[c];
                        m_run[c]  = 0;
                        posted[c] = 1;
                        newdir[c] = sample[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
        g = -1;
        if (m_valid) begin
            if (ev_ready) m_valid = 0;
        end else begin
            for (int k = 1; k <= NC; k++)
                if (g < 0 && m_pend[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
        end
        if (g >= 0) begin
            m_valid   = 1;
            m_ch      = g;
            m_rise    = m_dir[g];
            m_ptr     = g;
            m_pend[g] = 0;
        end
        if (ovf_clr) m_ovf = '0;
        for (int c = 0; c < NC; c++) begin
            if (posted[c]) begin
                if (m_pend[c]) m_ovf[c] = 1;
                m_pend[c] = 1;
                m_dir[c]  = newdir[c];
            end
        end
        m_cnt   = (!enable || tk) ? 0 : m_cnt + 1;
        hist[1] = hist[0];
        hist[0] = in;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("model", {20'd0, level, overflow, ev_valid, ev_ch, ev_rise},
                {20'd0, m_lvl, m_ovf, m_valid, 2'(m_ch), m_rise});
        end
    endtask

    typedef struct {
        logic [3:0] vin;
        logic       en, rdy, clr;
        int         cycles;
        logic [3:0] lvl;
        logic       vld;
        int         ch;
        logic       rise;
        logic [3:0] ovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int exp_ch [4];
        int waited;

        tbl.push_back('{4'b0000, 1, 0, 0, 12, 4'b0000, 0, 0, 0, 4'b0000});
        tbl.push_back('{4'b0010, 1, 0, 0, 30, 4'b0010, 1, 1, 1, 4'b0000});
        tbl.push_back('{4'b0010, 1, 1, 0,  1, 4'b0010, 0, 1, 1, 4'b0000});
        tbl.push_back('{4'b0011, 1, 0, 0, 10, 4'b0010, 0, 1, 1, 4'b0000});
        tbl.push_back('{4'b0010, 1, 0, 0, 20, 4'b0010, 0, 1, 1, 4'b0000});
        tbl.push_back('{4'b1010, 1, 0, 0, 30, 4'b1010, 1, 3, 1, 4'b0000});
        tbl.push_back('{4'b1110, 1, 0, 0, 30, 4'b1110, 1, 3, 1, 4'b0000});
        tbl.push_back('{4'b1010, 1, 0, 0, 30, 4'b1010, 1, 3, 1, 4'b0100});
        tbl.push_back('{4'b1010, 1, 1, 0,  1, 4'b1010, 0, 3, 1, 4'b0100});
        tbl.push_back('{4'b1010, 1, 1, 0,  1, 4'b1010, 1, 2, 0, 4'b0100});
        tbl.push_back('{4'b1010, 1, 1, 0,  1, 4'b1010, 0, 2, 0, 4'b0100});
        tbl.push_back('{4'b1010, 1, 1, 1,  1, 4'b1010, 0, 2, 0, 4'b0000});
        tbl.push_back('{4'b0101, 0, 1, 0, 40, 4'b1010, 0, 2, 0, 4'b0000});
        tbl.push_back('{4'b0101, 1, 1, 0,  9, 4'b1010, 0, 2, 0, 4'b0000});
        tbl.push_back('{4'b0101, 1, 1, 0,  1, 4'b1010, 0, 2, 0, 4'b0000});
        tbl.push_back('{4'b0101, 1, 1, 0, 10, 4'b0101, 0, 2, 0, 4'b0000});
        tbl.push_back('{4'b0101, 1, 1, 0,  1, 4'b0101, 1, 3, 0, 4'b0000});
        tbl.push_back('{4'b0101, 1, 1, 0,  1, 4'b0101, 0, 3, 0, 4'b0000});
        tbl.push_back('{4'b0101, 1, 1, 0,  1, 4'b0101, 1, 0, 1, 4'b0000});
        tbl.push_back('{4'b0101, 1, 1, 0,  1, 4'b0101, 0, 0, 1, 4'b0000});
        tbl.push_back('{4'b0101, 1, 1, 0,  1, 4'b0101, 1, 1, 0, 4'b0000});
        tbl.push_back('{4'b0101, 1, 1, 0,  1, 4'b0101, 0, 1, 0, 4'b0000});
        tbl.push_back('{4'b0101, 1, 1, 0,  1, 4'b0101, 1, 2, 1, 4'b0000});
        tbl.push_back('{4'b0101, 1, 1, 0,  1, 4'b0101, 0, 2, 1, 4'b0000});

        rst_n = 1'b0; in = '0; enable = 1'b1; ovf_clr = 1'b0; ev_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_state", {20'd0, level, overflow, ev_valid, ev_ch, ev_rise}, 32'd0);
        rst_n = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            in = tbl[r].vin; enable = tbl[r].en; ev_ready = tbl[r].rdy; ovf_clr = tbl[r].clr;
            step(tbl[r].cycles);
            chk($sformatf("row%0d_level", r), {28'd0, level}, {28'd0, tbl[r].lvl});
            chk($sformatf("row%0d_valid", r), {31'd0, ev_valid}, {31'd0, tbl[r].vld});
            chk($sformatf("row%0d_ch", r), {30'd0, ev_ch}, tbl[r].ch);
            chk($sformatf("row%0d_rise", r), {31'd0, ev_rise}, {31'd0, tbl[r].rise});
            chk($sformatf("row%0d_ovf", r), {28'd0, overflow}, {28'd0, tbl[r].ovf});
        end
        ovf_clr = 1'b0;

        // All channels rise together after reset: grants go 1,2,3,0.
        rst_n = 1'b0; #1; model_reset();
        @(negedge clk);
        rst_n = 1'b1; in = 4'b1111; enable = 1'b1; ev_ready = 1'b1;
        waited = 0;
        while (!ev_valid && waited < 40) begin
            step(1);
            waited++;
        end
        chk("simul_wait", {31'd0, ev_valid}, 32'd1);
        exp_ch = '{1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("simul_ch%0d", k), {29'd0, ev_valid, ev_ch}, {29'd0, 1'b1, 2'(exp_ch[k])});
            chk($sformatf("simul_rise%0d", k), {31'd0, ev_rise}, 32'd1);
            step(1);
            chk($sformatf("simul_gap%0d", k), {31'd0, ev_valid}, 32'd0);
            step(1);
        end

        // Reset while an event is presented and others are still pending.
        in = 4'b0000; ev_ready = 1'b0;
        waited = 0;
        while (!ev_valid && waited < 40) begin
            step(1);
            waited++;
        end
        chk("rst_wait", {31'd0, ev_valid}, 32'd1);
        step(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {20'd0, level, overflow, ev_valid, ev_ch, ev_rise}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; ev_ready = 1'b1;
        step(40);
        chk("no_stale_valid", {31'd0, ev_valid}, 32'd0);
        chk("no_stale_level", {28'd0, level}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NC; c++)
                if ($urandom_range(0, 11) == 0) in[c] = ~in[c];
            ev_ready = ($urandom_range(0, 2) != 0);
            ovf_clr  = ($urandom_range(0, 40) == 0);
            enable   = ($urandom_range(0, 60) != 0);
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/debounce_scan_arbiter.md
Name: debounce_scan_arbiter

Overview:
Multi-channel front-panel/trigger input controller. One shared sample-tick prescaler drives N debounce channels. A round-robin arbiter serialises their rise/fall events onto a single valid/ready event port for the command/register logic. It replaces per-input dividers and gives downstream logic one event stream with overflow reporting.

Parameters:
N_CH, 4, number of input channels (2..16)
DIV_WIDTH, 21, prescaler counter width
N_DIVIDE, 21'd2000000, tick period in clk cycles (100 MHz -> 50 Hz); must be >= 2
STABLE_CNT, 2, consecutive ticks a new level must persist before it is accepted (1..15)
CH_W, $clog2(N_CH), channel index width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
in  in  N_CH  raw asynchronous inputs
enable  in  1  1 = prescaler runs; 0 = prescaler held at 0, no ticks
ovf_clr  in  1  single-cycle pulse, clears all overflow bits
level  out  N_CH  debounced level per channel
ev_valid  out  1  event available
ev_ready  in  1  consumer accepts event
ev_ch  out  CH_W  channel of presented event
ev_rise  out  1  1 = rising edge, 0 = falling edge
overflow  out  N_CH  sticky per-channel lost-event flag

Behaviour:
- Reset: single clock domain on clk; reset asynchronous, active-low (rst_n), synchronous deassertion assumed upstream. All registers 0: level, overflow, ev_valid, ev_ch, ev_rise, prescaler, pending, agree counters, RR pointer, sync FFs.
- Synchroniser: 2-FF per input, always clocked, independent of tick.
- Prescaler: cnt 0..N_DIVIDE-1; tick = (cnt == N_DIVIDE-1) && enable; cnt wraps to 0 on tick. enable=0 forces cnt to 0 next cycle.
- Channel (on tick only):
  - sample != level: agree++.
  - When agree reaches STABLE_CNT: level flips, agree clears, event posted.
  - sample == level: agree clears (glitch rejected).
- Pending slot: one per channel (pend, dir).
  - Posting to an empty slot sets pend and dir.
  - Posting to an occupied slot overwrites dir with the newest edge and sets overflow[ch].
  - Post and arbiter-grant clear on the same channel in the same cycle: the post wins (pend stays 1, no overflow).
- Arbiter FSM, 2 states:
  - IDLE: if any pend, grant the first pending channel searching ptr+1, ptr+2, ... (mod N_CH). Load ev_ch/ev_rise, clear that pend, ptr <= granted, ev_valid <= 1, go PRESENT.
  - PRESENT: ev_valid, ev_ch and ev_rise held stable. On ev_ready: ev_valid <= 0, go IDLE.
  - ev_ready while ev_valid=0 is ignored.
  - Max throughput: 1 event per 2 clk.
- Latency: in change -> 2 clk sync -> accepted at STABLE_CNT-th following tick edge (level and pend update that cycle) -> ev_valid 1 clk later if IDLE.
- overflow: set as above, cleared by ovf_clr. Set and clear in the same cycle: set wins.
- Reset mid-operation: everything returns to reset values immediately; in-flight events are discarded.

Decomposition:
- Package debounce_pkg: ARB_IDLE/ARB_PRESENT state encoding, default divide constant, ev_rise polarity constant.
- Sub-module debounce_channel: one per channel, generate loop. Contains sync FFs, agree counter, level register and post strobe/dir. The top holds prescaler, pending slots, overflow and arbiter.

Test Plan:
- Config N_CH=4, N_DIVIDE=10, STABLE_CNT=2; in[1] 0->1 held -> level[1]=1 on the 2nd tick after sync; next clk ev_valid=1, ev_ch=1, ev_rise=1; ev_ready=1 -> ev_valid=0 next clk.
- Glitch: in[0] high for 1 tick then low -> level[0] stays 0, no event, agree back to 0.
- Simultaneous: in[0..3] all rise together, ev_ready tied 1 -> four events ch 1,2,3,0 (ptr starts 0), one every 2 clk.
- Backpressure/overflow: ev_ready=0, ch2 rise then fall while ch2 pend unserved -> overflow[2]=1, delivered event ch2 ev_rise=0; ovf_clr pulse -> overflow=0.
- enable=0 mid-count -> no ticks, level frozen despite in toggling; enable=1 -> ticks resume 10 clk later.
- rst_n asserted while ev_valid=1 with pending events -> all outputs 0 asynchronously; after release no stale events appear.
